div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 82 ++++++++
 tb/tb_div_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// One restoring-division step per valid cycle, registered with single-cycle latency.
// Chaining WIDTH steps from I = WIDTH-1 down to 0 with R = Q = 0 yields N / D and N % D.
module div_unit #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] I,
    output logic             valid_out,
    output logic [WIDTH-1:0] NO,
    output logic [WIDTH-1:0] QO,
    output logic [WIDTH-1:0] RO,
    output logic [WIDTH-1:0] IO
);

    localparam logic [WIDTH-1:0] WIDTH_L = WIDTH[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_L   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             valid_q;
    logic [WIDTH-1:0] n_q, q_q, r_q, i_q;
    logic [WIDTH-1:0] n_d, q_d, r_d, i_d;

    logic             in_range;
    logic [WIDTH-1:0] n_shift;
    logic             bit_sel;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] q_mask;

    // The shifted remainder is kept WIDTH+1 bits so R's MSB survives the compare.
    always_comb begin
        in_range = (I < WIDTH_L);
        n_shift  = N >> I;
        bit_sel  = in_range & n_shift[0];
        shifted  = {R, bit_sel};
        diff     = shifted - {1'b0, D};
        ge       = (shifted >= {1'b0, D});
        q_mask   = in_range ? (ONE_L << I) : '0;

        n_d = N;
        i_d = I - ONE_L;
        if (ge) begin
            r_d = diff[WIDTH-1:0];
            q_d = Q | q_mask;
        end else begin
            r_d = shifted[WIDTH-1:0];
            q_d = Q;
        end
    end

    // Results hold while idle; only valid_out follows valid_in every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            n_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            i_q     <= '0;
        end else begin
            valid_q <= valid_in;
            if (valid_in) begin
                n_q <= n_d;
                q_q <= q_d;
                r_q <= r_d;
                i_q <= i_d;
            end
        end
    end

    assign valid_out = valid_q;
    assign NO        = n_q;
    assign QO        = q_q;
    assign RO        = r_q;
    assign IO        = i_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vectors, random single steps and full division chains
// checked against an integer-arithmetic model of one restoring step.
module tb_div_unit;
  localparam int W   = 10;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [W-1:0] n_in, d_in, r_in, q_in, i_in;
  logic         valid_out;
  logic [W-1:0] no_o, qo_o, ro_o, io_o;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_no, exp_qo, exp_ro, exp_io;
  int exp_valid;

  div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .N         (n_in),
    .D         (d_in),
    .R         (r_in),
    .Q         (q_in),
    .I         (i_in),
    .valid_out (valid_out),
    .NO        (no_o),
    .QO        (qo_o),
    .RO        (ro_o),
    .IO        (io_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // One division step described directly from the arithmetic rules.
  task automatic model_step(input int n, d, r, q, i, output int no, qo, ro, io);
    int b, s;
    b  = (i < W) ? ((n >> i) & 1) : 0;
    s  = 2 * r + b;
    if (s >= d) begin
      ro = (s - d) % MOD;
      qo = (i < W) ? (q | (1 << i)) : q;
    end else begin
      ro = s % MOD;
      qo = q;
    end
    no = n;
    io = (i - 1 + MOD) % MOD;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, int'(valid_out), exp_valid);
    check({tag, ".NO"}, int'(no_o), exp_no);
    check({tag, ".QO"}, int'(qo_o), exp_qo);
    check({tag, ".RO"}, int'(ro_o), exp_ro);
    check({tag, ".IO"}, int'(io_o), exp_io);
  endtask

  // Drive one cycle, update the model, then sample 1 time unit after the edge.
  task automatic step(input bit rst_v, input bit v, input int n, d, r, q, i, input string tag);
    rst      = rst_v;
    valid_in = v;
    n_in     = W'(n);
    d_in     = W'(d);
    r_in     = W'(r);
    q_in     = W'(q);
    i_in     = W'(i);
    @(posedge clk);
    #1;
    if (rst_v) begin
      exp_valid = 0;
      exp_no = 0; exp_qo = 0; exp_ro = 0; exp_io = 0;
    end else if (v) begin
      exp_valid = 1;
      model_step(n, d, r, q, i, exp_no, exp_qo, exp_ro, exp_io);
    end else begin
      exp_valid = 0;
    end
    check_all(tag);
  endtask

  task automatic run_chain(input int n, d, input string tag);
    int r, q, i;
    r = 0; q = 0; i = W - 1;
    for (int k = 0; k < W; k++) begin
      step(1'b0, 1'b1, n, d, r, q, i, tag);
      r = exp_ro; q = exp_qo; i = exp_io;
    end
    check({tag, ".quot"}, int'(qo_o), n / d);
    check({tag, ".rem"}, int'(ro_o), n % d);
    check({tag, ".idx"}, int'(io_o), MOD - 1);
  endtask

  initial begin
    exp_valid = 0;
    exp_no = 0; exp_qo = 0; exp_ro = 0; exp_io = 0;

    // Reset with valid asserted, then an idle cycle after release.
    step(1'b1, 1'b1, 5, 3, 1, 1, 4, "reset");
    step(1'b1, 1'b0, 0, 0, 0, 0, 0, "reset2");
    step(1'b0, 1'b0, 9, 9, 9, 9, 9, "post_reset");
    check("post_reset.RO0", int'(ro_o), 0);

    // Directed vectors with literal expectations.
    step(1'b0, 1'b1, 'h160, 13, 8, 'h0AC, 2, "vec029");
    check("vec029.RO_lit", int'(ro_o), 3);
    check("vec029.QO_lit", int'(qo_o), 'h0AC);
    check("vec029.IO_lit", int'(io_o), 1);
    step(1'b0, 1'b1, 'h200, 14, 30, 'h0AC, 0, "vec030");
    check("vec030.RO_lit", int'(ro_o), 46);
    check("vec030.QO_lit", int'(qo_o), 'h0AD);
    check("vec030.IO_lit", int'(io_o), 'h3FF);
    step(1'b0, 1'b1, 4, 14, 8, 'h0AD, 15, "vec031");
    check("vec031.RO_lit", int'(ro_o), 2);
    check("vec031.QO_lit", int'(qo_o), 'h0AD);
    check("vec031.IO_lit", int'(io_o), 14);
    step(1'b0, 1'b1, 'h3FF, 1, 'h3FF, 0, 9, "vec032");
    check("vec032.RO_lit", int'(ro_o), 'h3FE);
    check("vec032.QO_lit", int'(qo_o), 'h200);
    check("vec032.IO_lit", int'(io_o), 8);

    // Idle cycles hold results; divisor zero is not trapped.
    step(1'b0, 1'b0, 1, 2, 3, 4, 5, "hold");
    step(1'b0, 1'b1, 'h3FF, 0, 'h155, 0, 3, "div0");

    run_chain(100, 7, "chain100_7");
    check("chain100_7.q_lit", int'(qo_o), 14);
    check("chain100_7.r_lit", int'(ro_o), 2);

    // Reset mid-chain, then a clean restart.
    step(1'b0, 1'b1, 100, 7, 0, 0, 9, "mid0");
    step(1'b0, 1'b1, 100, 7, exp_ro, exp_qo, exp_io, "mid1");
    step(1'b1, 1'b1, 100, 7, exp_ro, exp_qo, exp_io, "mid_rst");
    run_chain(100, 7, "restart");

    for (int c = 0; c < 20; c++)
      run_chain(int'($urandom_range(0, MOD - 1)), int'($urandom_range(1, MOD - 1)), "rchain");

    for (int k = 0; k < 300; k++) begin
      bit rv, vv;
      int dd;
      rv = ($urandom_range(0, 19) == 0);
      vv = ($urandom_range(0, 3) != 0);
      dd = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, MOD - 1));
      step(rv, vv, int'($urandom_range(0, MOD - 1)), dd,
           int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)),
           int'($urandom_range(0, 15)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
